// File: rtl/alu_multicycle.sv
// EX-stage ALU: single-cycle logic/arith/compare ops plus iterative mul/div writing HI/LO.
// Mul/div operate on magnitudes in a shared 2*WIDTH shift register; signs are applied in FIX.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] reg_data1,
  input  logic [WIDTH-1:0] reg_data2,
  input  logic [WIDTH-1:0] immediate_value,
  input  logic             alu_src,
  input  logic [3:0]       control_signals,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t             state_reg;
  logic [CW-1:0]      count_reg;
  logic [2*WIDTH-1:0] p_reg;        // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   mcand_reg;    // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   a_orig_reg;
  logic               neg_q_reg;
  logic               neg_r_reg;
  logic               is_div_reg;
  logic               b_zero_reg;

  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] and_bits, or_bits, nor_bits;
  logic [WIDTH-1:0] sum, diff;
  logic             slt_lt, sltu_lt;
  logic [WIDTH-1:0] sc_result;
  logic             sc_ovf, sc_known;

  assign op_a = reg_data1;
  assign op_b = alu_src ? immediate_value : reg_data2;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_logic
      assign and_bits[gi] = op_a[gi] & op_b[gi];
      assign or_bits[gi]  = op_a[gi] | op_b[gi];
      assign nor_bits[gi] = ~(op_a[gi] | op_b[gi]);
    end
  endgenerate

  assign sum     = op_a + op_b;
  assign diff    = op_a - op_b;
  assign slt_lt  = $signed(op_a) < $signed(op_b);
  assign sltu_lt = op_a < op_b;

  always_comb begin
    sc_result = '0;
    sc_ovf    = 1'b0;
    sc_known  = 1'b1;
    case (control_signals)
      OP_AND:  sc_result = and_bits;
      OP_OR:   sc_result = or_bits;
      OP_NOR:  sc_result = nor_bits;
      OP_ADD: begin
        sc_result = sum;
        sc_ovf    = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_result = diff;
        sc_ovf    = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, slt_lt};
      OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, sltu_lt};
      default: sc_known = 1'b0;
    endcase
  end

  // Opcodes 10xx are mul/div; bit 1 selects divide, bit 0 selects unsigned.
  logic             is_muldiv, md_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign is_muldiv = (control_signals[3:2] == 2'b10);
  assign md_signed = ~control_signals[0];
  assign a_neg     = md_signed & op_a[WIDTH-1];
  assign b_neg     = md_signed & op_b[WIDTH-1];
  assign a_mag     = a_neg ? -op_a : op_a;
  assign b_mag     = b_neg ? -op_b : op_b;

  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic [2*WIDTH-1:0] p_step;

  assign mul_sum   = {1'b0, p_reg[2*WIDTH-1:WIDTH]} + (p_reg[0] ? {1'b0, mcand_reg} : '0);
  assign div_shift = p_reg[2*WIDTH-1:WIDTH-1];
  assign div_trial = div_shift - {1'b0, mcand_reg};

  always_comb begin
    if (!is_div_reg)
      p_step = {mul_sum, p_reg[WIDTH-1:1]};
    else if (div_trial[WIDTH])
      p_step = {div_shift[WIDTH-1:0], p_reg[WIDTH-2:0], 1'b0};
    else
      p_step = {div_trial[WIDTH-1:0], p_reg[WIDTH-2:0], 1'b1};
  end

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix, fix_hi, fix_lo;

  assign prod_fix = neg_q_reg ? -p_reg : p_reg;
  assign quot_fix = neg_q_reg ? -p_reg[WIDTH-1:0] : p_reg[WIDTH-1:0];
  assign rem_fix  = neg_r_reg ? -p_reg[2*WIDTH-1:WIDTH] : p_reg[2*WIDTH-1:WIDTH];

  always_comb begin
    fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo = prod_fix[WIDTH-1:0];
    if (is_div_reg) begin
      fix_hi = b_zero_reg ? a_orig_reg : rem_fix;
      fix_lo = b_zero_reg ? '1 : quot_fix;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      p_reg       <= '0;
      mcand_reg   <= '0;
      a_orig_reg  <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      is_div_reg  <= 1'b0;
      b_zero_reg  <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      result      <= '0;
      hi          <= '0;
      lo          <= '0;
      zero        <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      // Flags are one-cycle pulses alongside out_valid.
      out_valid   <= 1'b0;
      zero        <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      if (flush) begin
        state_reg <= IDLE;
        in_ready  <= 1'b1;
      end else begin
        case (state_reg)
          IDLE: begin
            if (in_valid) begin
              in_ready <= 1'b0;
              if (is_muldiv) begin
                state_reg  <= BUSY;
                count_reg  <= '0;
                p_reg      <= {{WIDTH{1'b0}}, a_mag};
                mcand_reg  <= b_mag;
                a_orig_reg <= op_a;
                neg_q_reg  <= a_neg ^ b_neg;
                neg_r_reg  <= a_neg;
                is_div_reg <= control_signals[1];
                b_zero_reg <= (op_b == '0);
              end else begin
                state_reg <= DONE;
                out_valid <= 1'b1;
                result    <= sc_result;
                overflow  <= sc_ovf;
                zero      <= sc_known && (sc_result == '0);
              end
            end
          end
          BUSY: begin
            p_reg     <= p_step;
            count_reg <= count_reg + CW'(1);
            if (count_reg == CW'(WIDTH-1))
              state_reg <= FIX;
          end
          FIX: begin
            state_reg   <= DONE;
            out_valid   <= 1'b1;
            hi          <= fix_hi;
            lo          <= fix_lo;
            result      <= fix_lo;
            zero        <= (fix_lo == '0);
            div_by_zero <= is_div_reg & b_zero_reg;
          end
          default: begin
            state_reg <= IDLE;
            in_ready  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle at WIDTH=32 and WIDTH=8 with hand-computed expectations.
module tb_alu_multicycle;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush;
  logic        in_valid, alu_src;
  logic [3:0]  ctrl;
  logic [31:0] a, b, imm;
  logic        in_ready, out_valid, zero, overflow, dbz;
  logic [31:0] result, hi, lo;

  logic        in_valid8, alu_src8;
  logic [3:0]  ctrl8;
  logic [7:0]  a8, b8, imm8;
  logic        in_ready8, out_valid8, zero8, overflow8, dbz8;
  logic [7:0]  result8, hi8, lo8;

  int vectors = 0;
  int miscompares = 0;

  alu_multicycle #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .reg_data1(a), .reg_data2(b), .immediate_value(imm), .alu_src(alu_src),
    .control_signals(ctrl), .out_valid(out_valid), .result(result), .hi(hi), .lo(lo),
    .zero(zero), .overflow(overflow), .div_by_zero(dbz)
  );

  alu_multicycle #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid8), .in_ready(in_ready8),
    .reg_data1(a8), .reg_data2(b8), .immediate_value(imm8), .alu_src(alu_src8),
    .control_signals(ctrl8), .out_valid(out_valid8), .result(result8), .hi(hi8), .lo(lo8),
    .zero(zero8), .overflow(overflow8), .div_by_zero(dbz8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- WIDTH=32 helpers ----------------
  task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                       input logic src, input logic [31:0] iv);
    ctrl = op; a = av; b = bv; alu_src = src; imm = iv; in_valid = 1'b1;
    tick;
    in_valid = 1'b0; a = $urandom; b = $urandom; imm = $urandom;
  endtask

  task automatic sc(input string tag, input logic [3:0] op, input logic [31:0] av,
                    input logic [31:0] bv, input logic src, input logic [31:0] iv,
                    input logic [31:0] er, input logic ez, input logic eo);
    issue(op, av, bv, src, iv);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_res"}, result, er);
    chk({tag, "_zero"}, zero, ez);
    chk({tag, "_ovf"}, overflow, eo);
    chk({tag, "_busy"}, in_ready, 0);
    $display("op %s A=%h B=%h -> result=%h zero=%0b ovf=%0b", tag, av, src ? iv : bv, result, zero, overflow);
    tick;
    chk({tag, "_pulse"}, {out_valid, zero, overflow}, 0);
    chk({tag, "_ready"}, in_ready, 1);
  endtask

  task automatic wait_done(output int n, output int rdy_bad);
    n = 1; rdy_bad = 0;
    while (!out_valid && n < 200) begin
      if (in_ready) rdy_bad++;
      tick;
      n++;
    end
    if (in_ready) rdy_bad++;
  endtask

  task automatic md(input string tag, input logic [3:0] op, input logic [31:0] av,
                    input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo,
                    input logic edbz);
    int n, rb;
    issue(op, av, bv, 1'b0, 32'h0);
    wait_done(n, rb);
    chk({tag, "_lat"}, n, 34);
    chk({tag, "_stall"}, rb, 0);
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
    chk({tag, "_res"}, result, elo);
    chk({tag, "_flags"}, {zero, overflow, dbz}, {elo == 32'h0, 1'b0, edbz});
    $display("op %s A=%h B=%h -> hi=%h lo=%h dbz=%0b lat=%0d", tag, av, bv, hi, lo, dbz, n);
    tick;
    chk({tag, "_pulse"}, {out_valid, dbz}, 0);
    chk({tag, "_ready"}, in_ready, 1);
  endtask

  // ---------------- WIDTH=8 helpers ----------------
  task automatic issue8(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv,
                        input logic src, input logic [7:0] iv);
    ctrl8 = op; a8 = av; b8 = bv; alu_src8 = src; imm8 = iv; in_valid8 = 1'b1;
    tick;
    in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); imm8 = 8'($urandom);
  endtask

  task automatic sc8(input string tag, input logic [3:0] op, input logic [7:0] av,
                     input logic [7:0] bv, input logic src, input logic [7:0] iv,
                     input logic [7:0] er, input logic ez, input logic eo);
    issue8(op, av, bv, src, iv);
    chk({tag, "_valid"}, out_valid8, 1);
    chk({tag, "_res"}, result8, er);
    chk({tag, "_flags"}, {zero8, overflow8}, {ez, eo});
    $display("op8 %s A=%h B=%h -> result=%h zero=%0b ovf=%0b", tag, av, src ? iv : bv, result8, zero8, overflow8);
    tick;
    chk({tag, "_pulse"}, {out_valid8, zero8, overflow8, in_ready8}, 4'b0001);
  endtask

  task automatic md8(input string tag, input logic [3:0] op, input logic [7:0] av,
                     input logic [7:0] bv, input logic [7:0] ehi, input logic [7:0] elo,
                     input logic edbz);
    int n, rb;
    issue8(op, av, bv, 1'b0, 8'h0);
    n = 1; rb = 0;
    while (!out_valid8 && n < 100) begin
      if (in_ready8) rb++;
      tick;
      n++;
    end
    chk({tag, "_lat"}, n, 10);
    chk({tag, "_stall"}, rb, 0);
    chk({tag, "_hilo"}, {hi8, lo8, result8}, {ehi, elo, elo});
    chk({tag, "_flags"}, {overflow8, dbz8}, {1'b0, edbz});
    $display("op8 %s A=%h B=%h -> hi=%h lo=%h dbz=%0b lat=%0d", tag, av, bv, hi8, lo8, dbz8, n);
    tick;
    chk({tag, "_pulse"}, {out_valid8, dbz8, in_ready8}, 3'b001);
  endtask

  initial begin
    int seen;
    reset = 1'b1; flush = 1'b0;
    in_valid = 1'b0; alu_src = 1'b0; ctrl = 4'h0; a = '0; b = '0; imm = '0;
    in_valid8 = 1'b0; alu_src8 = 1'b0; ctrl8 = 4'h0; a8 = '0; b8 = '0; imm8 = '0;

    #12;
    chk("reset_outs", {out_valid, result, hi, lo, zero, overflow, dbz}, 0);
    chk("reset_ready", in_ready, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    tick;

    // Single-cycle ops
    sc("add_ovf",  4'b0011, 32'h7FFFFFFF, 32'h1, 0, 0, 32'h80000000, 0, 1);
    sc("add_wrap", 4'b0011, 32'hFFFFFFFF, 32'h1, 0, 0, 32'h0, 1, 0);
    sc("sub_imm",  4'b0010, 32'h5, 32'h63, 1, 32'h5, 32'h0, 1, 0);
    sc("sub_ovf",  4'b0010, 32'h80000000, 32'h1, 0, 0, 32'h7FFFFFFF, 0, 1);
    sc("slt",      4'b0110, 32'hFFFFFFFF, 32'h1, 0, 0, 32'h1, 0, 0);
    sc("sltu",     4'b0111, 32'hFFFFFFFF, 32'h1, 0, 0, 32'h0, 1, 0);
    sc("and",      4'b0000, 32'hF0F000FF, 32'h0FF00F0F, 0, 0, 32'h00F0000F, 0, 0);
    sc("or",       4'b0001, 32'hF0F000FF, 32'h0FF00F0F, 0, 0, 32'hFFF00FFF, 0, 0);
    sc("nor",      4'b1100, 32'hF0F000FF, 32'h0FF00F0F, 0, 0, 32'h000FF000, 0, 0);
    sc("unknown",  4'b0100, 32'h12345678, 32'h9, 0, 0, 32'h0, 0, 0);

    // Flush alongside in_valid in IDLE must not accept the op
    flush = 1'b1;
    issue(4'b0011, 32'h1, 32'h1, 0, 0);
    flush = 1'b0;
    chk("flush_idle_valid", out_valid, 0);
    chk("flush_idle_ready", in_ready, 1);
    tick;
    chk("flush_idle_late", out_valid, 0);

    // Multiply / divide
    md("mult",      4'b1000, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
    md("multu_max", 4'b1001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
    md("mult_min",  4'b1000, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);
    md("div_neg",   4'b1010, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    md("div_negb",  4'b1010, 32'h7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0);
    md("div_minm1", 4'b1010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0);
    md("div_by0",   4'b1010, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1);
    md("divu_by0",  4'b1011, 32'h7, 32'h0, 32'h7, 32'hFFFFFFFF, 1);
    md("divu",      4'b1011, 32'd100, 32'd7, 32'd2, 32'd14, 0);

    // Flush at BUSY step 10 of a multu
    issue(4'b1001, 32'h3, 32'h5, 0, 0);
    repeat (10) tick;
    chk("flush_busy_pre", in_ready, 0);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("flush_busy_idle", {in_ready, out_valid}, 2'b10);
    seen = 0;
    repeat (40) begin
      if (out_valid) seen++;
      tick;
    end
    chk("flush_no_valid", seen, 0);
    chk("flush_hilo", {hi, lo}, {32'd2, 32'd14});
    $display("flush multu at step 10 -> hi=%h lo=%h out_valid_seen=%0d", hi, lo, seen);

    // Asynchronous reset in the middle of a divide
    issue(4'b1010, 32'd100, 32'd7, 0, 0);
    repeat (4) tick;
    chk("rst_pre_busy", in_ready, 0);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_outs", {out_valid, result, hi, lo, zero, overflow, dbz}, 0);
    chk("rst_async_ready", in_ready, 1);
    $display("async reset mid-div -> result=%h hi=%h lo=%h in_ready=%0b", result, hi, lo, in_ready);
    #3 reset = 1'b0;
    tick;
    sc("post_rst_add", 4'b0011, 32'h2, 32'h3, 0, 0, 32'h5, 0, 0);

    // WIDTH=8 regression
    sc8("add_ovf",  4'b0011, 8'h7F, 8'h01, 0, 0, 8'h80, 0, 1);
    sc8("sub_imm",  4'b0010, 8'h05, 8'h33, 1, 8'h05, 8'h00, 1, 0);
    sc8("slt",      4'b0110, 8'hFF, 8'h01, 0, 0, 8'h01, 0, 0);
    sc8("sltu",     4'b0111, 8'hFF, 8'h01, 0, 0, 8'h00, 1, 0);
    md8("mult",     4'b1000, 8'hFD, 8'h07, 8'hFF, 8'hEB, 0);
    md8("div_neg",  4'b1010, 8'hF9, 8'h02, 8'hFF, 8'hFD, 0);
    md8("divu_by0", 4'b1011, 8'h07, 8'h00, 8'h07, 8'hFF, 1);
    md8("div_minm1",4'b1010, 8'h80, 8'hFF, 8'h00, 8'h80, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
